decode_stage: RTL
=================

# decode_stage

Instruction decode stage of the pipelined RISC-V core, sitting between the IF/ID boundary and the execute stage. It drives the register file read ports and generates the immediate. It resolves operand hazards by forwarding from EX, MEM and WB, and by inserting a one-cycle bubble on load-use. Its output is the registered ID/EX pipeline register.

## Interface
- XLEN, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- id_ready  out  1  decode accepts the instruction this cycle; upstream holds its instruction when low
- flush  in  1  taken branch/jump resolved in EX; kill the instruction in ID
- rs1_addr, rs2_addr  out  5  register file read addresses (combinational, from if_instr)
- rs1, rs2  in  XLEN  register file read data (combinational; x0 reads 0)
- ex_result  in  XLEN  combinational ALU result of the instruction currently in ID/EX
- mem_rd_addr  in  5, mem_reg_write  in  1, mem_result  in  XLEN  EX/MEM writeback info (load data included)
- wb_rd_addr  in  5, wb_reg_write  in  1, wb_data  in  XLEN  same values driven to the register file write port
- ex_valid  out  1
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN
- ex_rd_addr, ex_rs1_addr, ex_rs2_addr  out  5
- ex_opcode  out  7, ex_funct3  out  3, ex_funct7b5  out  1
- ex_reg_write, ex_is_load  out  1

## Operation
- Field decode from if_instr: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7b5[30].
- rs1 is used unless opcode is LUI, AUIPC or JAL. rs2 is used for OP, STORE and BRANCH.
- reg_write is set for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, and only when rd != 0. is_load is set for LOAD.
- Immediate: I, S, B, U and J formats by opcode, sign-extended to XLEN. Other opcodes produce 0.
- Operand select, per source, first match wins:
  - ID/EX: ex_valid && ex_reg_write && ex_rd_addr == src, uses ex_result
  - MEM: mem_reg_write && mem_rd_addr == src, uses mem_result
  - WB: wb_reg_write && wb_rd_addr == src, uses wb_data
  - otherwise the register file value
- src == 0 always yields 0, with no forwarding.
- Load-use stall: asserted when if_valid && ex_valid && ex_is_load && ex_rd_addr != 0, and a used rs1 or a used rs2 equals ex_rd_addr.
- id_ready = flush || !stall.
- Next-state priority at each clock edge:
  - flush: ex_valid <= 0.
  - else stall: bubble, ex_valid <= 0.
  - else: load all ex_* fields, with ex_valid <= if_valid.
- A bubble clears ex_reg_write and ex_is_load. Other ex_* fields are don't-care while ex_valid = 0.

## Timing
- Reset (asynchronous, rst_n low): all ex_* outputs are 0, ex_valid = 0. Release is synchronous to clk.
- Latency: one cycle from acceptance to ex_* valid.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM and the operand comes from mem_result.
- Simultaneous flush and stall: flush wins. id_ready = 1 and the ID instruction is dropped.
- Simultaneous write and read of the same register from WB: wb_data is forwarded. The register file write becomes visible only after the edge.
- Multiple matching sources: the youngest wins (EX > MEM > WB).
- if_valid = 0: no stall is raised and a bubble enters ID/EX.

## Structure
- riscv_pkg holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - an imm_fmt_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}
- Sub-module imm_gen: combinational, instr → XLEN immediate.
- Forwarding and hazard logic stay inline.

## Test plan
- ADDI x1,x0,5 with a register-file stub returning 0 → next cycle ex_valid=1, ex_imm=5, ex_rd_addr=1, ex_reg_write=1.
- ADD x3,x1,x2 while the ID/EX instruction writes x1 (ex_result=7) and MEM writes x2 (mem_result=9) → ex_rs1_val=7, ex_rs2_val=9.
- LW x5 in ID/EX, then ADD x6,x5,x0 in ID → id_ready=0 for one cycle and a bubble is issued. The following cycle, with mem_result=0x1234, ex_rs1_val=0x1234.
- flush=1 during a load-use stall → id_ready=1, ex_valid=0 next cycle, and the next instruction decodes normally.
- Every source writes x0 with data 0xFFFF_FFFF, and ADD x7,x0,x0 is in ID → ex_rs1_val=ex_rs2_val=0.
- rst_n low mid-stream (asynchronous, between edges) → all ex_* outputs are 0 immediately. After release, a BEQ with offset -4 produces ex_imm=0xFFFF_FFFC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 decode definitions.
//   XLEN          datapath width
//   OP..AUIPC     major opcode encodings (instr[6:0])
//   imm_fmt_t     immediate format selected by the opcode
//   imm_fmt_of()  opcode -> immediate format
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OP_IMM, LOAD, JALR: fmt = IMM_I;
      STORE:              fmt = IMM_S;
      BRANCH:             fmt = IMM_B;
      LUI, AUIPC:         fmt = IMM_U;
      JAL:                fmt = IMM_J;
      default:            fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate generator.
//   instr  in   32    instruction word
//   imm    out  XLEN  sign-extended immediate (0 for formats without one)
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  // Each raw immediate is built at its natural width as a signed value; the
  // size cast to XLEN then performs the sign extension.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    imm = '0;
    case (imm_fmt_of(instr[6:0]))
      IMM_I: imm = XLEN'($signed(instr[31:20]));
      IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                  instr[11:8], 1'b0}));
      IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32 instruction decode with operand forwarding, load-use
// stall and the registered ID/EX pipeline register.
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc    IF/ID contents; id_ready low holds them upstream
//   flush                      kill the instruction in ID (redirect from EX)
//   rs1_addr/rs2_addr, rs1/rs2 register file read port
//   ex_result                  ALU result of the instruction in ID/EX
//   mem_*, wb_*                later-stage writeback info for forwarding
//   ex_*                       ID/EX pipeline register outputs
module decode_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] ex_result,
  input  logic [4:0]      mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd_addr,
  output logic [4:0]      ex_rs1_addr,
  output logic [4:0]      ex_rs2_addr,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_is_load
);

  // Field decode
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic       funct7b5;

  assign opcode   = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign funct3   = if_instr[14:12];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];
  assign funct7b5 = if_instr[30];

  logic rs1_used, rs2_used, reg_write, is_load;

  assign rs1_used  = !(opcode == LUI || opcode == AUIPC || opcode == JAL);
  assign rs2_used  = (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);
  assign reg_write = (rd != 5'd0) &&
                     (opcode == OP  || opcode == OP_IMM || opcode == LOAD  ||
                      opcode == LUI || opcode == AUIPC  || opcode == JAL   ||
                      opcode == JALR);
  assign is_load   = (opcode == LOAD);

  logic [XLEN-1:0] imm;

  imm_gen u_imm_gen (
    .instr (if_instr),
    .imm   (imm)
  );

  // Operand forwarding: youngest producer wins. x0 is hard-wired to zero and
  // never forwarded, so a producer that nominally targets x0 cannot leak.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      src,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_hit_ok,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_val,
    input logic            mem_we,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_val,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    if (src == 5'd0)                    return '0;
    else if (ex_hit_ok && ex_rd == src) return ex_val;
    else if (mem_we && mem_rd == src)   return mem_val;
    else if (wb_we && wb_rd == src)     return wb_val;
    else                                return rf_val;
  endfunction

  logic            ex_fwd_ok;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign ex_fwd_ok = ex_valid && ex_reg_write;

  always_comb begin
    rs1_val = fwd_sel(rs1_addr, rs1, ex_fwd_ok, ex_rd_addr, ex_result,
                      mem_reg_write, mem_rd_addr, mem_result,
                      wb_reg_write, wb_rd_addr, wb_data);
    rs2_val = fwd_sel(rs2_addr, rs2, ex_fwd_ok, ex_rd_addr, ex_result,
                      mem_reg_write, mem_rd_addr, mem_result,
                      wb_reg_write, wb_rd_addr, wb_data);
  end

  // Load-use: the load's data is not available until it reaches MEM, so the
  // dependent instruction waits one cycle and then picks it up from mem_result.
  logic stall;

  assign stall = if_valid && ex_valid && ex_is_load && (ex_rd_addr != 5'd0) &&
                 ((rs1_used && rs1_addr == ex_rd_addr) ||
                  (rs2_used && rs2_addr == ex_rd_addr));

  // A flush discards the ID instruction anyway, so the stall is irrelevant.
  assign id_ready = flush || !stall;

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd_addr   <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
    end else if (flush || stall) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
    end else begin
      ex_valid     <= if_valid;
      ex_pc        <= if_pc;
      ex_rs1_val   <= rs1_val;
      ex_rs2_val   <= rs2_val;
      ex_imm       <= imm;
      ex_rd_addr   <= rd;
      ex_rs1_addr  <= rs1_addr;
      ex_rs2_addr  <= rs2_addr;
      ex_opcode    <= opcode;
      ex_funct3    <= funct3;
      ex_funct7b5  <= funct7b5;
      ex_reg_write <= if_valid && reg_write;
      ex_is_load   <= if_valid && is_load;
    end
  end

endmodule
